// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA-256 message feeder.
//   SHA256_IV   : initial hash value, H0 in [255:224]
//   BLOCK_BITS  : compression block width
//   STATE_BITS  : chaining state width
//   LEN_FIELD   : width of the trailing bit-length field
//   feeder_state_e / pad_mode_e : feeder FSM states and tail-builder modes
package sha_pkg;

  localparam int unsigned BLOCK_BITS  = 512;
  localparam int unsigned STATE_BITS  = 256;
  localparam int unsigned LEN_FIELD   = 64;
  localparam int unsigned BLOCK_BYTES = BLOCK_BITS / 8;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned FIT_LIMIT   = 55;

  localparam logic [STATE_BITS-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_START,
    ST_WAIT,
    ST_LENBLK,
    ST_OUT
  } feeder_state_e;

  typedef enum logic [1:0] {
    PAD_NORMAL,
    PAD_LENBLK,
    PAD_NEXT
  } pad_mode_e;

endpackage

// File: rtl/sha_pad_tail.sv
// Combinational SHA-256 tail builder.
//   blk_buf : partially filled block, byte 0 at [511:504]
//   idx     : first free byte position
//   bit_len : message length in bits
//   mode    : PAD_NORMAL (data + 0x80 + zeros [+ length]),
//             PAD_LENBLK (zeros + length), PAD_NEXT (0x80 + zeros + length)
//   block   : resulting 512-bit block
//   fits    : length field fits after the 0x80 byte (idx <= 55)
module sha_pad_tail
  import sha_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] blk_buf,
  input  logic [IDX_W-1:0]      idx,
  input  logic [LEN_FIELD-1:0]  bit_len,
  input  pad_mode_e             mode,
  output logic [BLOCK_BITS-1:0] block,
  output logic                  fits
);

  assign fits = (idx <= IDX_W'(FIT_LIMIT));

  always_comb begin
    block = '0;
    case (mode)
      PAD_NORMAL: begin
        // keep buffered bytes below idx, terminator at idx, zeros above
        for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
          if (i < int'(idx)) begin
            block[(BLOCK_BYTES-1-i)*8 +: 8] = blk_buf[(BLOCK_BYTES-1-i)*8 +: 8];
          end else if (i == int'(idx)) begin
            block[(BLOCK_BYTES-1-i)*8 +: 8] = 8'h80;
          end
        end
        if (fits) block[LEN_FIELD-1:0] = bit_len;
      end
      PAD_NEXT: begin
        block[BLOCK_BITS-1 -: 8] = 8'h80;
        block[LEN_FIELD-1:0]     = bit_len;
      end
      default: begin
        block[LEN_FIELD-1:0] = bit_len;
      end
    endcase
  end

endmodule

// File: rtl/sha_msg_feeder.sv
// SHA-256 message feeder: buffers a byte stream into 512-bit blocks, pads
// the message, drives sha_core block by block with chained state and
// returns the final digest over a valid/ready handshake.
//   clk, rst (sync, active low)
//   in_valid/in_ready/in_byte/in_last/in_skip : message byte stream
//   core_start/core_message/core_state        : block request to sha_core
//   core_done/core_result                     : sha_core completion
//   digest_valid/digest/digest_ready          : final digest output
module sha_msg_feeder
  import sha_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  input  logic                  in_skip,
  output logic                  core_start,
  output logic [BLOCK_BITS-1:0] core_message,
  output logic [STATE_BITS-1:0] core_state,
  input  logic                  core_done,
  input  logic [STATE_BITS-1:0] core_result,
  output logic                  digest_valid,
  output logic [STATE_BITS-1:0] digest,
  input  logic                  digest_ready
);

  feeder_state_e         state;
  logic [BLOCK_BITS-1:0] blk_buf;
  logic [BLOCK_BITS-1:0] buf_wr;
  logic [BLOCK_BITS-1:0] tail_blk;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      pos;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_FIELD-1:0]  bit_len;
  logic                  final_blk;
  logic                  pad_next;
  logic                  lenblk_pend;
  logic                  done_q;
  logic                  fits;
  logic                  beat;
  logic                  is_data;
  logic                  done_edge;
  pad_mode_e             mode;

  assign in_ready  = (state == ST_FILL);
  assign beat      = in_valid & in_ready;
  assign is_data   = ~(in_last & in_skip);
  assign done_edge = core_done & ~done_q;
  assign bit_len   = LEN_FIELD'({cnt, 3'b000});

  // byte idx lives at bit offset (63 - idx) * 8; 63 - idx is ~idx in 6 bits
  assign pos = ~idx;

  // buffer with the incoming byte merged in
  always_comb begin
    buf_wr = blk_buf;
    buf_wr[{pos, 3'b000} +: 8] = in_byte;
  end

  // LENBLK state builds either the zero+length block or the 0x80-led block
  always_comb begin
    mode = PAD_NORMAL;
    if (state == ST_LENBLK) mode = pad_next ? PAD_NEXT : PAD_LENBLK;
  end

  sha_pad_tail u_pad_tail (
    .blk_buf (blk_buf),
    .idx     (idx),
    .bit_len (bit_len),
    .mode    (mode),
    .block   (tail_blk),
    .fits    (fits)
  );

  // feeder FSM with registered outputs
  always_ff @(posedge clk) begin
    done_q <= core_done;
    if (!rst) begin
      state        <= ST_FILL;
      blk_buf      <= '0;
      idx          <= '0;
      cnt          <= '0;
      final_blk    <= 1'b0;
      pad_next     <= 1'b0;
      lenblk_pend  <= 1'b0;
      core_start   <= 1'b0;
      core_message <= '0;
      core_state   <= SHA256_IV;
      digest_valid <= 1'b0;
      digest       <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_FILL: begin
          if (beat) begin
            if (is_data) begin
              blk_buf <= buf_wr;
              idx     <= idx + IDX_W'(1);
              cnt     <= cnt + LEN_W'(1);
            end
            if (is_data && (idx == IDX_W'(BLOCK_BYTES - 1))) begin
              core_message <= buf_wr;
              core_start   <= 1'b1;
              final_blk    <= 1'b0;
              pad_next     <= in_last;
              state        <= ST_START;
            end else if (in_last) begin
              state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          core_message <= tail_blk;
          core_start   <= 1'b1;
          final_blk    <= fits;
          lenblk_pend  <= ~fits;
          state        <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // only a fresh rising edge completes the block
          if (done_edge) begin
            core_state <= core_result;
            if (final_blk) begin
              digest       <= core_result;
              digest_valid <= 1'b1;
              state        <= ST_OUT;
            end else begin
              idx   <= '0;
              state <= (lenblk_pend || pad_next) ? ST_LENBLK : ST_FILL;
            end
          end
        end
        ST_LENBLK: begin
          core_message <= tail_blk;
          core_start   <= 1'b1;
          final_blk    <= 1'b1;
          lenblk_pend  <= 1'b0;
          pad_next     <= 1'b0;
          state        <= ST_START;
        end
        ST_OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            core_state   <= SHA256_IV;
            state        <= ST_FILL;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Scoreboard bench for sha_msg_feeder with a behavioural SHA-256 responder.
module tb_sha_msg_feeder;
  import sha_pkg::*;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] KAT_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] KAT_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] KAT_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         in_skip;
  logic         core_start;
  logic [511:0] core_message;
  logic [255:0] core_state;
  logic         core_done;
  logic [255:0] core_result;
  logic         digest_valid;
  logic [255:0] digest;
  logic         digest_ready;

  sha_msg_feeder #(.LEN_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .in_skip      (in_skip),
    .core_start   (core_start),
    .core_message (core_message),
    .core_state   (core_state),
    .core_done    (core_done),
    .core_result  (core_result),
    .digest_valid (digest_valid),
    .digest       (digest),
    .digest_ready (digest_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_blk_q [$];
  logic [255:0] exp_st_q  [$];
  logic [255:0] exp_dig_q [$];
  logic [7:0]   cur_msg   [$];
  logic [255:0] last_digest;
  int exp_start_cyc = -1;
  int start_count   = 0;
  int dig_count     = 0;
  int last_done_cyc = 0;
  int ready_delay   = 0;
  int resp_lat_min  = 1;
  bit abort         = 1'b0;
  bit busy          = 1'b0;

  task automatic check_v(input string name, input logic [511:0] act, input logic [511:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected event within bound", name);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // plain SHA-256 compression of one block
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // reference: pad the byte queue, split into blocks, chain the state
  task automatic model_msg();
    logic [7:0]   p [$];
    logic [63:0]  bl;
    logic [255:0] h;
    logic [511:0] b;
    p  = cur_msg;
    bl = 64'(cur_msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = SHA256_IV;
    for (int n = 0; n < p.size() / 64; n++) begin
      for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[n*64 + j];
      exp_blk_q.push_back(b);
      exp_st_q.push_back(h);
      h = compress(h, b);
    end
    exp_dig_q.push_back(h);
  endtask

  task automatic set_str(input string s);
    cur_msg.delete();
    for (int i = 0; i < s.len(); i++) cur_msg.push_back(s[i]);
  endtask

  // called at a falling edge; returns one falling edge after the transfer
  task automatic send_beat(input logic [7:0] b, input bit last, input bit skip, input int pos);
    int t;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1; in_byte = b; in_last = last; in_skip = skip;
    t = 0;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_event("beat_accept_timeout");
    else if (!skip && pos == 63) exp_start_cyc = cyc + 1;
    else if (last) exp_start_cyc = cyc + 2;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_skip = 1'b0;
  endtask

  task automatic send_msg(input bit use_skip);
    int n;
    n = cur_msg.size();
    for (int i = 0; i < n; i++) send_beat(cur_msg[i], (i == n - 1) && !use_skip, 1'b0, i % 64);
    if (n == 0 || use_skip) send_beat(8'h00, 1'b1, 1'b1, n % 64);
  endtask

  task automatic wait_digests(input int target);
    int t;
    t = 0;
    while (dig_count < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (dig_count < target) fail_event("digest_timeout");
  endtask

  task automatic run_msg(input bit use_skip, input int delay);
    int tgt;
    model_msg();
    ready_delay = delay;
    tgt = dig_count + 1;
    send_msg(use_skip);
    wait_digests(tgt);
  endtask

  // sha_core responder: computes the compression after a random latency
  initial begin : responder
    logic [511:0] m;
    logic [255:0] s;
    bit saw;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      if (core_start) begin
        busy = 1'b1;
        m = core_message;
        s = core_state;
        saw = 1'b0;
        // a level still high from the previous block must not complete this one
        if (core_done) begin
          repeat (2) begin @(posedge clk); #1; if (in_ready) saw = 1'b1; end
          core_done = 1'b0;
        end
        repeat ($urandom_range(resp_lat_min, resp_lat_min + 5)) begin
          @(posedge clk); #1;
          if (in_ready) saw = 1'b1;
        end
        if (!abort) begin
          check_i("in_ready_during_wait", int'(saw), 0);
          check_i("block_stable_until_done", int'(core_message == m && core_state == s), 1);
        end
        core_result = compress(s, m);
        core_done = 1'b1;
        last_done_cyc = cyc;
        if ($urandom_range(0, 1) == 0) begin
          @(posedge clk); #1;
          core_done = 1'b0;
        end
        busy = 1'b0;
      end
    end
  end

  // monitor: pops expected blocks/digests as the DUT presents them
  initial begin : monitor
    bit prev_start;
    bit prev_dv;
    bit rdy_was;
    int wcnt;
    logic [255:0] held;
    prev_start = 1'b0; prev_dv = 1'b0; rdy_was = 1'b0; wcnt = 0; held = '0;
    digest_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        prev_start = 1'b0; prev_dv = 1'b0; rdy_was = 1'b0; digest_ready = 1'b0;
        continue;
      end
      if (prev_start) check_i("start_one_cycle", int'(core_start), 0);
      if (core_start) begin
        start_count++;
        if (exp_blk_q.size() == 0) fail_event("unexpected_block");
        else begin
          check_v("block_message", core_message, exp_blk_q.pop_front());
          check_v("block_state", 512'(core_state), 512'(exp_st_q.pop_front()));
        end
        if (exp_start_cyc >= 0) begin
          check_i("start_latency", cyc, exp_start_cyc);
          exp_start_cyc = -1;
        end
      end
      prev_start = core_start;
      if (rdy_was) begin
        check_i("digest_valid_after_xfer", int'(digest_valid), 0);
        check_i("in_ready_after_xfer", int'(in_ready), 1);
        if (exp_dig_q.size() != 0) void'(exp_dig_q.pop_front());
        last_digest = held;
        dig_count++;
        rdy_was = 1'b0;
        digest_ready = 1'b0;
      end else if (digest_valid) begin
        if (!prev_dv) begin
          held = digest;
          wcnt = 0;
          check_i("digest_latency", cyc, last_done_cyc + 1);
          if (exp_dig_q.size() == 0) fail_event("unexpected_digest");
          else check_v("digest_value", 512'(digest), 512'(exp_dig_q[0]));
        end else begin
          check_v("digest_stable", 512'(digest), 512'(held));
        end
        if (wcnt >= ready_delay) begin
          digest_ready = 1'b1;
          rdy_was = 1'b1;
        end else begin
          wcnt++;
        end
      end
      prev_dv = digest_valid;
    end
  end

  task automatic check_reset_values(input string tag);
    check_i({tag, "_in_ready"}, int'(in_ready), 1);
    check_i({tag, "_core_start"}, int'(core_start), 0);
    check_v({tag, "_core_message"}, core_message, 512'(0));
    check_v({tag, "_core_state"}, 512'(core_state), 512'(SHA256_IV));
    check_i({tag, "_digest_valid"}, int'(digest_valid), 0);
    check_v({tag, "_digest"}, 512'(digest), 512'(0));
  endtask

  initial begin : main
    int lens [13];
    int sc;
    int dc;
    int t;
    int n;
    lens = '{0, 1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};
    in_valid = 1'b0; in_byte = '0; in_last = 1'b0; in_skip = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);

    set_str("abc");
    run_msg(1'b0, 2);
    check_v("kat_abc", 512'(last_digest), 512'(KAT_ABC));

    cur_msg.delete();
    run_msg(1'b1, 0);
    check_v("kat_empty", 512'(last_digest), 512'(KAT_EMPTY));

    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg(1'b0, 1);
    check_v("kat_56", 512'(last_digest), 512'(KAT_56));

    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnop");
    run_msg(1'b1, 3);

    cur_msg.delete();
    for (int i = 0; i < 64; i++) cur_msg.push_back(8'h61);
    run_msg(1'b0, 0);

    // reset while waiting on sha_core, then resend
    set_str("abc");
    model_msg();
    ready_delay = 10;
    resp_lat_min = 4;
    sc = start_count;
    dc = dig_count;
    send_msg(1'b0);
    t = 0;
    while (start_count == sc && t < 100) begin @(negedge clk); t++; end
    if (start_count == sc) fail_event("reset_case_start");
    @(negedge clk);
    abort = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b1;
    void'(exp_dig_q.pop_back());
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check_i("no_digest_after_abort", int'(digest_valid), 0);
    abort = 1'b0;
    resp_lat_min = 1;
    set_str("abc");
    run_msg(1'b0, 10);
    check_v("kat_abc_after_reset", 512'(last_digest), 512'(KAT_ABC));
    check_i("one_digest_after_reset", dig_count - dc, 1);

    // boundary lengths and random lengths with random content
    for (int k = 0; k < 19; k++) begin
      n = (k < 13) ? lens[k] : int'($urandom_range(0, 200));
      cur_msg.delete();
      for (int i = 0; i < n; i++) cur_msg.push_back(8'($urandom_range(0, 255)));
      run_msg(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    repeat (5) @(negedge clk);
    check_i("blocks_all_seen", exp_blk_q.size(), 0);
    check_i("digests_all_seen", exp_dig_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_msg_feeder.md
# sha_msg_feeder

Initiator for the SHA-256 compression core (`sha_core`). Accepts a message as a byte stream, buffers it into 512-bit blocks, and applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length). It drives each block into `sha_core` through the start/done handshake, chaining each block's result into the next block's `start_state`, and presents the final 256-bit digest to the miner control logic with a valid/ready handshake.

## Interface
- `LEN_W`, default 32: width of the internal message byte counter. The bit length is `{cnt, 3'b000}`, zero-extended to 64 bits.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: byte-stream valid.
- `in_ready` out 1: byte-stream ready.
- `in_byte` in 8: message byte.
- `in_last` in 1: this beat ends the message.
- `in_skip` in 1: valid only with `in_last`. The beat carries no data, which allows an empty message or a terminator after the final byte.
- `core_start` out 1: one-cycle start pulse to `sha_core`.
- `core_message` out 512: padded block. Byte 0 of the block is at [511:504].
- `core_state` out 256: chaining input. H0 is at [255:224].
- `core_done` in 1: completion flag from `sha_core`.
- `core_result` in 256: updated state from `sha_core`, same packing as `core_state`.
- `digest_valid` out 1: final digest available.
- `digest` out 256: final digest.
- `digest_ready` in 1: consumer accepts the digest.

## Operation
- States:
  - FILL: accept bytes.
  - PAD: build the tail in one cycle.
  - START: pulse `core_start`.
  - WAIT: wait for the `core_done` rising edge.
  - LENBLK: build an all-zero block followed by the length.
  - OUT: hold the digest.
- FILL:
  - `in_ready=1`. A beat transfers on `in_valid & in_ready`.
  - A data byte is written at index `idx`, then `idx` and `cnt` increment.
  - When byte 63 is written without `in_last`: go to START with `final=0`.
  - When byte 63 is written with `in_last`: go to START with `final=0` and `pad_next=1`. The next block is 0x80, zeros, then the length.
  - A beat with `in_last` at any other position (data or skip): go to PAD.
- PAD, with `idx` = the first free byte:
  - byte[idx]=0x80, and every later byte is 0x00.
  - If `idx`≤55: bytes 56..63 hold the length, then go to START with `final=1`.
  - Otherwise: go to START with `final=0`, then LENBLK.
- LENBLK: block = 56 zero bytes plus the length. Go to START with `final=1`.
- After a non-final full-data block with `pad_next`: build the next block with the 0x80 at byte 0 plus the length, with `final=1`.
- START: `core_start=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - Capture `core_result` on the first cycle where `core_done=1` and the registered `core_done` is 0.
  - `core_state` takes the captured result.
  - If `final`: go to OUT. Otherwise: clear `idx` and go to FILL, or to LENBLK or the pad_next block as pending.
- First block of every message: `core_state` = IV (6a09e667 … 5be0cd19).
- OUT:
  - `digest_valid=1` and `digest` is held stable.
  - On `digest_ready`: clear `cnt`, `idx` and the chain flag, load IV, and go to FILL.
- `core_message` and `core_state` are stable from the START cycle until the `core_done` edge.
- `cnt` wraps modulo 2^LEN_W. No error is flagged.

## Timing
- Reset values:
  - state=FILL, `in_ready=1`, `core_start=0`, `core_message=0`, `core_state`=IV, `digest_valid=0`, `digest=0`, `idx=0`, `cnt=0`.
- Reset asserted mid-operation, in any state: the next edge returns to FILL with the values above.
  - The message in progress is discarded.
  - A later `core_done` edge is ignored unless START has occurred since reset.
- `in_ready` is combinational from the state. It is 0 in PAD, START, WAIT, LENBLK and OUT.
- Full-block path: `core_start` is high on the cycle after the 64th byte's transfer.
- Terminal path: last beat, then PAD, then `core_start` one cycle after PAD.
- `digest_valid` rises on the cycle after the captured `core_done` edge of the final block.
- `digest_valid` and `digest_ready` high in the same cycle: transfer, and `in_ready=1` on the next cycle.
- `core_done` already high at START (stale from the previous block): it does not complete the block. Only a 0→1 edge after START does.

## Structure
- `sha_pkg` holds:
  - The SHA-256 IV constant, BLOCK_BITS=512, STATE_BITS=256, LEN_FIELD=64.
  - The feeder state enum.
- Sub-module `sha_pad_tail` (combinational): inputs are the block buffer, `idx`, the 64-bit length and mode (normal, lenblk, pad_next). Outputs are the 512-bit block and the `fits` flag (idx≤55).

## Test plan
All scenarios use a real `sha_core` as the responder.
- "abc" (3 bytes, `in_last` on 'c'): one block with length 0x18; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (single `in_last`+`in_skip` beat): block 0x80, zeros, length 0; digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdef…nopq": two blocks, the second all-zero plus length 0x1c0; digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. Check that `core_state` on block 2 equals the block-1 result.
- 55-byte "abcdbcde…mnop": single block with the length 0x1b8 in the same block. The 64-byte message 'a'×64: two blocks, the second starting with 0x80 and ending with length 0x200. Check `in_ready=0` throughout WAIT.
- Reset mid-operation:
  - Assert `rst=0` for one cycle during WAIT of "abc", then send "abc" again.
  - Exactly one digest is produced, and it is the correct one.
  - Hold `digest_ready=0` for 10 cycles: `digest_valid` and `digest` stay stable.
